// File: rtl/fl_pkg.sv
// fl_pkg: shared sizing and tag types for the rename-stage free list.
package fl_pkg;
    localparam int PR_WIDTH             = 7;
    localparam int AR_NUM               = 32;
    localparam int FL_SIZE              = 32;
    localparam int FL_IDX_WIDTH         = $clog2(FL_SIZE);
    localparam int PR_NUM               = AR_NUM + FL_SIZE;
    localparam int VERILOG_CLOCK_PERIOD = 10;

    typedef logic [PR_WIDTH-1:0]     pr_tag_t;
    typedef logic [FL_IDX_WIDTH-1:0] fl_idx_t;
    typedef logic [FL_IDX_WIDTH:0]   fl_cnt_t;
endpackage

// File: rtl/fl.sv
// fl: 2-wide circular free list of physical register tags with
// retire-side commit pointer for rollback on ROB recovery.
module fl
    import fl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] rob_dispatch_num,
    input  logic [1:0] rob_retire_num,
    input  pr_tag_t    rob_told0,
    input  pr_tag_t    rob_told1,
    input  logic       rob_recover,
    output pr_tag_t    fl_pr0,
    output pr_tag_t    fl_pr1,
    output logic [1:0] fl_avail_num,
    output logic       fl_empty
);
    pr_tag_t    entry [FL_SIZE];
    fl_idx_t    head, tail, rhead;
    fl_cnt_t    count, next_count;
    logic [1:0] avail, disp, ret, n;

    function automatic fl_idx_t adv(input fl_idx_t p, input logic [1:0] k);
        return p + fl_idx_t'(k);
    endfunction

    always_comb begin
        avail      = count >= fl_cnt_t'(2) ? 2'd2 : count[1:0];
        disp       = rob_dispatch_num == 2'd3 ? 2'd2 : rob_dispatch_num;
        ret        = rob_retire_num == 2'd3 ? 2'd2 : rob_retire_num;
        n          = rob_recover ? 2'd0 : (disp > avail ? avail : disp);
        next_count = count - fl_cnt_t'(n) + fl_cnt_t'(ret);
    end

    // Recovery: committed state maps exactly AR_NUM tags, so every entry is free again
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) entry[i] <= pr_tag_t'(AR_NUM + i);
            head  <= '0;
            tail  <= '0;
            rhead <= '0;
            count <= fl_cnt_t'(FL_SIZE);
        end else begin
            if (ret != 2'd0) entry[tail] <= rob_told0;
            if (ret == 2'd2) entry[adv(tail, 2'd1)] <= rob_told1;
            tail  <= adv(tail, ret);
            rhead <= adv(rhead, ret);
            head  <= rob_recover ? adv(rhead, ret) : adv(head, n);
            count <= rob_recover ? fl_cnt_t'(FL_SIZE) : next_count;
        end
    end

    assign fl_pr0       = entry[head];
    assign fl_pr1       = entry[adv(head, 2'd1)];
    assign fl_avail_num = avail;
    assign fl_empty     = count == '0;

    a_dispatch: assert property (@(posedge clock) disable iff (reset)
        rob_recover || (rob_dispatch_num != 2'd3 && rob_dispatch_num <= avail))
        else $error("fl: dispatch request exceeds available tags");

    a_overflow: assert property (@(posedge clock) disable iff (reset)
        rob_recover || next_count <= fl_cnt_t'(FL_SIZE))
        else $error("fl: retire overflows free list");
endmodule

// File: tb/tb_fl.sv
// tb_fl: directed scenario bench for the free list.
module tb_fl;
    import fl_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rob_dispatch_num = 2'd0;
    logic [1:0] rob_retire_num = 2'd0;
    pr_tag_t    rob_told0 = '0;
    pr_tag_t    rob_told1 = '0;
    logic       rob_recover = 1'b0;
    pr_tag_t    fl_pr0, fl_pr1;
    logic [1:0] fl_avail_num;
    logic       fl_empty;
    int         vectors = 0;
    int         miscompares = 0;

    fl dut (
        .clock(clock), .reset(reset),
        .rob_dispatch_num(rob_dispatch_num), .rob_retire_num(rob_retire_num),
        .rob_told0(rob_told0), .rob_told1(rob_told1), .rob_recover(rob_recover),
        .fl_pr0(fl_pr0), .fl_pr1(fl_pr1), .fl_avail_num(fl_avail_num), .fl_empty(fl_empty)
    );

    always #(VERILOG_CLOCK_PERIOD / 2) clock = ~clock;

    task automatic drive(input logic [1:0] d, input logic [1:0] r,
                         input pr_tag_t t0, input pr_tag_t t1, input logic rec);
        rob_dispatch_num = d;
        rob_retire_num   = r;
        rob_told0        = t0;
        rob_told1        = t1;
        rob_recover      = rec;
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1);
            vectors++;
            if (fl_pr0 !== 7'd32) begin miscompares++; $display("FAIL reset_pr0 cyc%0d got %0d exp 32", c, fl_pr0); end
            vectors++;
            if (fl_pr1 !== 7'd33) begin miscompares++; $display("FAIL reset_pr1 cyc%0d got %0d exp 33", c, fl_pr1); end
            vectors++;
            if (fl_avail_num !== 2'd2) begin miscompares++; $display("FAIL reset_avail cyc%0d got %0d exp 2", c, fl_avail_num); end
            vectors++;
            if (fl_empty !== 1'b0) begin miscompares++; $display("FAIL reset_empty cyc%0d got %0b exp 0", c, fl_empty); end
        end
    endtask

    task automatic test_dispatch();
        do_reset();
        drive(2'd2, 2'd0, '0, '0, 1'b0);
        tick(1);
        vectors++;
        if (fl_pr0 !== 7'd34) begin miscompares++; $display("FAIL disp2_pr0 got %0d exp 34", fl_pr0); end
        vectors++;
        if (fl_pr1 !== 7'd35) begin miscompares++; $display("FAIL disp2_pr1 got %0d exp 35", fl_pr1); end
        drive(2'd1, 2'd0, '0, '0, 1'b0);
        tick(1);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_pr0 !== 7'd35) begin miscompares++; $display("FAIL disp1_pr0 got %0d exp 35", fl_pr0); end
        vectors++;
        if (fl_pr1 !== 7'd36) begin miscompares++; $display("FAIL disp1_pr1 got %0d exp 36", fl_pr1); end
        vectors++;
        if (dut.count !== 6'd29) begin miscompares++; $display("FAIL disp1_count got %0d exp 29", dut.count); end
    endtask

    task automatic test_drain();
        do_reset();
        drive(2'd2, 2'd0, '0, '0, 1'b0);
        tick(15);
        vectors++;
        if (fl_avail_num !== 2'd2) begin miscompares++; $display("FAIL drain15_avail got %0d exp 2", fl_avail_num); end
        vectors++;
        if (fl_pr0 !== 7'd62) begin miscompares++; $display("FAIL drain15_pr0 got %0d exp 62", fl_pr0); end
        tick(1);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %0b exp 1", fl_empty); end
        vectors++;
        if (fl_avail_num !== 2'd0) begin miscompares++; $display("FAIL drain_avail got %0d exp 0", fl_avail_num); end
        drive(2'd0, 2'd1, 7'd3, '0, 1'b0);
        tick(1);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_pr0 !== 7'd3) begin miscompares++; $display("FAIL refill_pr0 got %0d exp 3", fl_pr0); end
        vectors++;
        if (fl_avail_num !== 2'd1) begin miscompares++; $display("FAIL refill_avail got %0d exp 1", fl_avail_num); end
        vectors++;
        if (fl_empty !== 1'b0) begin miscompares++; $display("FAIL refill_empty got %0b exp 0", fl_empty); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(2'd2, 2'd0, '0, '0, 1'b0);
        tick(15);
        for (int i = 0; i < 15; i++) begin
            drive(2'd0, 2'd2, pr_tag_t'(2 * i), pr_tag_t'(2 * i + 1), 1'b0);
            tick(1);
        end
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (dut.count !== 6'd32) begin miscompares++; $display("FAIL wrap_full_count got %0d exp 32", dut.count); end
        vectors++;
        if (fl_pr0 !== 7'd62 || fl_pr1 !== 7'd63) begin miscompares++; $display("FAIL wrap_h30 got %0d/%0d exp 62/63", fl_pr0, fl_pr1); end
        drive(2'd1, 2'd0, '0, '0, 1'b0);
        tick(1);
        vectors++;
        if (fl_pr0 !== 7'd63 || fl_pr1 !== 7'd0) begin miscompares++; $display("FAIL wrap_h31 got %0d/%0d exp 63/0", fl_pr0, fl_pr1); end
        drive(2'd2, 2'd0, '0, '0, 1'b0);
        tick(1);
        vectors++;
        if (fl_pr0 !== 7'd1 || fl_pr1 !== 7'd2) begin miscompares++; $display("FAIL wrap_h1 got %0d/%0d exp 1/2", fl_pr0, fl_pr1); end
        drive(2'd1, 2'd0, '0, '0, 1'b0);
        tick(1);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_pr0 !== 7'd2 || fl_pr1 !== 7'd3) begin miscompares++; $display("FAIL wrap_h2 got %0d/%0d exp 2/3", fl_pr0, fl_pr1); end
        vectors++;
        if (dut.count !== 6'd28) begin miscompares++; $display("FAIL wrap_count got %0d exp 28", dut.count); end
    endtask

    task automatic test_recover();
        do_reset();
        drive(2'd2, 2'd0, '0, '0, 1'b0);
        tick(2);
        vectors++;
        if (fl_pr0 !== 7'd36) begin miscompares++; $display("FAIL rec_pre_pr0 got %0d exp 36", fl_pr0); end
        drive(2'd2, 2'd1, 7'd5, '0, 1'b1);
        tick(1);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_pr0 !== 7'd33) begin miscompares++; $display("FAIL rec_pr0 got %0d exp 33", fl_pr0); end
        vectors++;
        if (fl_pr1 !== 7'd34) begin miscompares++; $display("FAIL rec_pr1 got %0d exp 34", fl_pr1); end
        vectors++;
        if (dut.count !== 6'd32) begin miscompares++; $display("FAIL rec_count got %0d exp 32", dut.count); end
        vectors++;
        if (dut.entry[0] !== 7'd5) begin miscompares++; $display("FAIL rec_entry0 got %0d exp 5", dut.entry[0]); end
        drive(2'd2, 2'd0, '0, '0, 1'b0);
        tick(1);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_pr0 !== 7'd35 || fl_pr1 !== 7'd36) begin miscompares++; $display("FAIL rec_after_disp got %0d/%0d exp 35/36", fl_pr0, fl_pr1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(2'd2, 2'd1, 7'd9, '0, 1'b0);
        tick(3);
        drive(2'd0, 2'd0, '0, '0, 1'b0);
        vectors++;
        if (fl_pr0 === 7'd32) begin miscompares++; $display("FAIL areset_pre got %0d exp not 32", fl_pr0); end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (fl_pr0 !== 7'd32 || fl_pr1 !== 7'd33) begin miscompares++; $display("FAIL areset_pr got %0d/%0d exp 32/33", fl_pr0, fl_pr1); end
        vectors++;
        if (dut.count !== 6'd32) begin miscompares++; $display("FAIL areset_count got %0d exp 32", dut.count); end
        vectors++;
        if (fl_avail_num !== 2'd2 || fl_empty !== 1'b0) begin miscompares++; $display("FAIL areset_flags got %0d/%0b exp 2/0", fl_avail_num, fl_empty); end
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_drain();
        test_wrap();
        test_recover();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
